// File: rtl/timer_host_sequencer_if.sv
// Avalon-MM link between the sequencer (master) and the interval timer s1 port (slave),
// including the timer's level interrupt.
interface timer_host_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/timer_host_sequencer.sv
// Autonomous Avalon master for the interval timer: programs period/control, clears each
// timeout, counts serviced ticks and fetches 32-bit counter snapshots on request.
module timer_host_sequencer #(
  parameter logic [31:0] PERIOD     = 32'd49999,
  parameter bit          CONTINUOUS = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          snap_req,
  timer_host_sequencer_if.master        bus,
  output logic                          tick,
  output logic [31:0]                   tick_count,
  output logic [31:0]                   snapshot,
  output logic                          snapshot_valid,
  output logic                          busy
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR,
    SNAP_W, SNAP_RL, SNAP_RH, SNAP_DONE, WR_STOP
  } state_t;

  localparam logic [15:0] CTRL_START = CONTINUOUS ? 16'h0007 : 16'h0005;
  localparam logic [15:0] CTRL_STOP  = 16'h0008;

  state_t      state_reg, state_next;
  logic        stop_pending_reg;
  logic        snap_pending_reg;
  logic        tick_reg;
  logic [31:0] tick_count_reg;
  logic [31:0] snapshot_reg;
  logic        snapshot_valid_reg;

  always_comb begin
    state_next     = state_reg;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 16'h0000;
    case (state_reg)
      IDLE: if (start) state_next = WR_PL;
      WR_PL: begin
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        bus.address = 3'd2; bus.writedata = PERIOD[15:0];
        state_next = WR_PH;
      end
      WR_PH: begin
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        bus.address = 3'd3; bus.writedata = PERIOD[31:16];
        state_next = WR_CTRL;
      end
      WR_CTRL: begin
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        bus.address = 3'd1; bus.writedata = CTRL_START;
        state_next = RUN;
      end
      RUN: begin
        if (stop || stop_pending_reg) state_next = WR_STOP;
        else if (bus.irq)             state_next = CLR;
        else if (snap_pending_reg)    state_next = SNAP_W;
      end
      CLR: begin
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        bus.address = 3'd0;
        state_next = CONTINUOUS ? RUN : WR_STOP;
      end
      SNAP_W: begin
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        bus.address = 3'd4;
        state_next = SNAP_RL;
      end
      SNAP_RL: begin
        bus.chipselect = 1'b1; bus.address = 3'd4;
        state_next = SNAP_RH;
      end
      SNAP_RH: begin
        bus.chipselect = 1'b1; bus.address = 3'd5;
        state_next = SNAP_DONE;
      end
      SNAP_DONE: state_next = RUN;
      WR_STOP: begin
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        bus.address = 3'd1; bus.writedata = CTRL_STOP;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // tick and tick_count both update on the edge that enters CLR, so the pulse
  // lines up with the clear write and the count is already current while tick is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= IDLE;
      stop_pending_reg   <= 1'b0;
      snap_pending_reg   <= 1'b0;
      tick_reg           <= 1'b0;
      tick_count_reg     <= 32'd0;
      snapshot_reg       <= 32'd0;
      snapshot_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (state_reg == IDLE || state_reg == WR_STOP) stop_pending_reg <= 1'b0;
      else if (stop && state_reg != RUN)             stop_pending_reg <= 1'b1;

      if (state_reg == SNAP_DONE)                 snap_pending_reg <= 1'b0;
      else if (snap_req && state_reg != IDLE)     snap_pending_reg <= 1'b1;

      tick_reg <= (state_next == CLR) && (state_reg == RUN);
      if ((state_next == CLR) && (state_reg == RUN))
        tick_count_reg <= tick_count_reg + 32'd1;

      if (state_reg == SNAP_RH)   snapshot_reg[15:0]  <= bus.readdata;
      if (state_reg == SNAP_DONE) snapshot_reg[31:16] <= bus.readdata;
      snapshot_valid_reg <= (state_reg == SNAP_DONE);
    end
  end

  assign tick           = tick_reg;
  assign tick_count     = tick_count_reg;
  assign snapshot       = snapshot_reg;
  assign snapshot_valid = snapshot_valid_reg;
  assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_timer_host_sequencer.sv
// Directed bench: two sequencers (continuous and one-shot, PERIOD=9) against a small timer
// model that logs bus traffic and returns a preset counter snapshot on reads of 4/5.
module tb_timer_host_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic start1 = 0, stop1 = 0, snap1 = 0, start2 = 0, stop2 = 0, snap2 = 0;
  logic tick1, tick2, valid1, valid2, busy1, busy2;
  logic [31:0] count1, count2, snapshot1, snapshot2;
  logic [31:0] snap_val1 = 32'h0;

  timer_host_sequencer_if bus1();
  timer_host_sequencer_if bus2();

  timer_host_sequencer #(.PERIOD(32'd9), .CONTINUOUS(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .stop(stop1), .snap_req(snap1),
    .bus(bus1), .tick(tick1), .tick_count(count1), .snapshot(snapshot1),
    .snapshot_valid(valid1), .busy(busy1));

  timer_host_sequencer #(.PERIOD(32'd9), .CONTINUOUS(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .stop(stop2), .snap_req(snap2),
    .bus(bus2), .tick(tick2), .tick_count(count2), .snapshot(snapshot2),
    .snapshot_valid(valid2), .busy(busy2));

  int vectors = 0;
  int miscompares = 0;

  logic [18:0] wlog1[$];
  logic [18:0] wlog2[$];
  logic [2:0]  rlog1[$];
  logic [18:0] exp_w[$];
  int ticks1 = 0;

  initial begin
    bus1.irq = 1'b0;
    bus2.irq = 1'b0;
  end
  assign bus2.readdata = 16'h0000;

  // Timer model: registered read data, one cycle after the address.
  always @(posedge clk) begin
    if (bus1.chipselect && bus1.write_n)
      bus1.readdata <= (bus1.address == 3'd4) ? snap_val1[15:0] :
                       (bus1.address == 3'd5) ? snap_val1[31:16] : 16'h0000;
    else
      bus1.readdata <= 16'h0000;
  end

  always @(posedge clk) begin
    if (bus1.chipselect) begin
      if (!bus1.write_n) wlog1.push_back({bus1.address, bus1.writedata});
      else               rlog1.push_back(bus1.address);
    end
    if (bus2.chipselect && !bus2.write_n) wlog2.push_back({bus2.address, bus2.writedata});
    if (tick1) ticks1++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({bus1.chipselect, bus1.write_n, bus1.address, bus1.writedata} !== {1'b0, 1'b1, 3'd0, 16'h0}) begin
      miscompares++;
      $display("FAIL reset_bus got cs=%b wn=%b a=%0d d=%h want cs=0 wn=1 a=0 d=0000",
               bus1.chipselect, bus1.write_n, bus1.address, bus1.writedata);
    end
    vectors++;
    if ({busy1, tick1, valid1, count1, snapshot1} !== {3'b000, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_regs got busy=%b tick=%b valid=%b count=%h snap=%h want all 0",
               busy1, tick1, valid1, count1, snapshot1);
    end
    reset_n = 1'b1;
    step();
    $display("reset: done");
  endtask

  task automatic test_program();
    wlog1.delete();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    vectors++;
    if ({bus1.chipselect, bus1.write_n, bus1.address, bus1.writedata} !== {1'b1, 1'b0, 3'd2, 16'h0009}) begin
      miscompares++;
      $display("FAIL first_write got cs=%b wn=%b a=%0d d=%h want cs=1 wn=0 a=2 d=0009",
               bus1.chipselect, bus1.write_n, bus1.address, bus1.writedata);
    end
    repeat (4) step();
    exp_w = '{{3'd2, 16'h0009}, {3'd3, 16'h0000}, {3'd1, 16'h0007}};
    vectors++;
    if (wlog1.size() != exp_w.size()) begin
      miscompares++;
      $display("FAIL prog_count got %0d writes want %0d", wlog1.size(), exp_w.size());
    end else begin
      foreach (exp_w[i]) begin
        vectors++;
        if (wlog1[i] !== exp_w[i]) begin
          miscompares++;
          $display("FAIL prog_write%0d got %h want %h", i, wlog1[i], exp_w[i]);
        end
      end
    end
    vectors++;
    if ({busy1, bus1.chipselect, bus1.write_n} !== 3'b101) begin
      miscompares++;
      $display("FAIL prog_idle got busy=%b cs=%b wn=%b want busy=1 cs=0 wn=1",
               busy1, bus1.chipselect, bus1.write_n);
    end
    $display("program: %0d writes logged", wlog1.size());
  endtask

  task automatic test_irq();
    int t0;
    wlog1.delete();
    t0 = ticks1;
    for (int k = 0; k < 5; k++) begin
      bus1.irq = 1'b1;
      step();
      vectors++;
      if ({tick1, bus1.chipselect, bus1.write_n, bus1.address, bus1.writedata} !== {3'b110, 3'd0, 16'h0}) begin
        miscompares++;
        $display("FAIL irq%0d_tick got tick=%b cs=%b wn=%b a=%0d want tick=1 cs=1 wn=0 a=0",
                 k, tick1, bus1.chipselect, bus1.write_n, bus1.address);
      end
      step();
      bus1.irq = 1'b0;
      repeat (8) step();
      $display("irq %0d: tick_count=%0d", k, count1);
    end
    vectors++;
    if (count1 !== 32'd5) begin
      miscompares++;
      $display("FAIL irq_count got %0d want 5", count1);
    end
    vectors++;
    if (ticks1 - t0 != 5 || wlog1.size() != 5) begin
      miscompares++;
      $display("FAIL irq_pulses got ticks=%0d clr_writes=%0d want 5 and 5", ticks1 - t0, wlog1.size());
    end
  endtask

  task automatic test_snapshot();
    int n;
    snap_val1 = 32'h0001_0004;
    wlog1.delete();
    rlog1.delete();
    snap1 = 1'b1;
    step();
    snap1 = 1'b0;
    for (n = 0; n < 20 && !valid1; n++) step();
    vectors++;
    if (n != 5) begin
      miscompares++;
      $display("FAIL snap_latency got %0d cycles want 5", n);
    end
    vectors++;
    if (snapshot1 !== 32'h0001_0004) begin
      miscompares++;
      $display("FAIL snap_value got %h want 00010004", snapshot1);
    end
    vectors++;
    if (wlog1.size() != 1 || rlog1.size() != 2) begin
      miscompares++;
      $display("FAIL snap_traffic got %0d writes %0d reads want 1 and 2", wlog1.size(), rlog1.size());
    end else begin
      vectors++;
      if ({wlog1[0][18:16], rlog1[0], rlog1[1]} !== {3'd4, 3'd4, 3'd5}) begin
        miscompares++;
        $display("FAIL snap_addr got w=%0d r=%0d,%0d want w=4 r=4,5", wlog1[0][18:16], rlog1[0], rlog1[1]);
      end
    end
    step();
    vectors++;
    if (valid1 !== 1'b0) begin
      miscompares++;
      $display("FAIL snap_pulse got valid=%b want 0 one cycle later", valid1);
    end
    $display("snapshot: value=%h", snapshot1);
  endtask

  task automatic test_irq_and_snap();
    int n;
    snap_val1 = 32'h1234_ABCD;
    wlog1.delete();
    bus1.irq = 1'b1;
    snap1 = 1'b1;
    step();
    snap1 = 1'b0;
    vectors++;
    if (tick1 !== 1'b1) begin
      miscompares++;
      $display("FAIL both_tick got %b want 1", tick1);
    end
    step();
    bus1.irq = 1'b0;
    for (n = 0; n < 20 && !valid1; n++) step();
    vectors++;
    if (n == 20 || snapshot1 !== 32'h1234_ABCD) begin
      miscompares++;
      $display("FAIL both_snap got %h (waited %0d) want 1234abcd", snapshot1, n);
    end
    vectors++;
    if (count1 !== 32'd6) begin
      miscompares++;
      $display("FAIL both_count got %0d want 6", count1);
    end
    vectors++;
    if (wlog1.size() != 2 || wlog1[0][18:16] !== 3'd0 || wlog1[1][18:16] !== 3'd4) begin
      miscompares++;
      $display("FAIL both_order got %0d writes first=%h want clr(0) then snap(4)",
               wlog1.size(), wlog1.size() > 0 ? wlog1[0] : 19'h0);
    end
    $display("irq+snap: count=%0d snapshot=%h", count1, snapshot1);
  endtask

  task automatic test_stop();
    wlog1.delete();
    stop1 = 1'b1;
    step();
    stop1 = 1'b0;
    vectors++;
    if ({bus1.chipselect, bus1.write_n, bus1.address, bus1.writedata} !== {1'b1, 1'b0, 3'd1, 16'h0008}) begin
      miscompares++;
      $display("FAIL stop_write got cs=%b wn=%b a=%0d d=%h want cs=1 wn=0 a=1 d=0008",
               bus1.chipselect, bus1.write_n, bus1.address, bus1.writedata);
    end
    step();
    vectors++;
    if (busy1 !== 1'b0 || wlog1.size() != 1) begin
      miscompares++;
      $display("FAIL stop_idle got busy=%b writes=%0d want busy=0 writes=1", busy1, wlog1.size());
    end
    $display("stop: busy=%b", busy1);
  endtask

  task automatic test_one_shot();
    wlog2.delete();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    repeat (4) step();
    vectors++;
    if (wlog2.size() != 3 || wlog2[2] !== {3'd1, 16'h0005}) begin
      miscompares++;
      $display("FAIL oneshot_ctrl got %0d writes last=%h want 3 writes last=10005",
               wlog2.size(), wlog2.size() > 0 ? wlog2[wlog2.size()-1] : 19'h0);
    end
    wlog2.delete();
    bus2.irq = 1'b1;
    step();
    vectors++;
    if (tick2 !== 1'b1) begin
      miscompares++;
      $display("FAIL oneshot_tick got %b want 1", tick2);
    end
    step();
    bus2.irq = 1'b0;
    step();
    exp_w = '{{3'd0, 16'h0000}, {3'd1, 16'h0008}};
    vectors++;
    if (wlog2.size() != 2 || wlog2[0] !== exp_w[0] || wlog2[1] !== exp_w[1]) begin
      miscompares++;
      $display("FAIL oneshot_writes got %0d writes want (0,0000) then (1,0008)", wlog2.size());
    end
    vectors++;
    if (busy2 !== 1'b0 || count2 !== 32'd1) begin
      miscompares++;
      $display("FAIL oneshot_end got busy=%b count=%0d want busy=0 count=1", busy2, count2);
    end
    $display("one-shot: count=%0d busy=%b", count2, busy2);
  endtask

  task automatic test_reset_mid();
    wlog1.delete();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    vectors++;
    if (bus1.address !== 3'd3) begin
      miscompares++;
      $display("FAIL mid_state got a=%0d want 3 (WR_PH)", bus1.address);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus1.chipselect, bus1.write_n, bus1.address, busy1} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset got cs=%b wn=%b a=%0d busy=%b want cs=0 wn=1 a=0 busy=0",
               bus1.chipselect, bus1.write_n, bus1.address, busy1);
    end
    step();
    reset_n = 1'b1;
    repeat (3) step();
    vectors++;
    if (wlog1.size() != 1 || wlog1[0] !== {3'd2, 16'h0009}) begin
      miscompares++;
      $display("FAIL mid_nowrite got %0d writes want only (2,0009)", wlog1.size());
    end
    vectors++;
    if (count1 !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_count got %0d want 0", count1);
    end
    force dut1.tick_count_reg = 32'hFFFF_FFFF;
    step();
    release dut1.tick_count_reg;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (4) step();
    bus1.irq = 1'b1;
    step();
    vectors++;
    if (tick1 !== 1'b1 || count1 !== 32'd0) begin
      miscompares++;
      $display("FAIL wrap got tick=%b count=%h want tick=1 count=00000000", tick1, count1);
    end
    step();
    bus1.irq = 1'b0;
    step();
    $display("reset-mid/wrap: count=%h", count1);
  endtask

  initial begin
    test_reset();
    test_program();
    test_irq();
    test_snapshot();
    test_irq_and_snap();
    test_stop();
    test_one_shot();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
